// File: rtl/io_pkg.sv
// Shared IO-subsystem definitions used by the RLE compressor, the
// decompressor stage and the DMA glue.
//   DATA_W      raw/encoded word width
//   CNT_W       run counter width (<= DATA_W), MAX_RUN = 2**CNT_W-1
//   HEADER_MASK bit position of first_bit inside the header word
//   state_t     compressor FSM states
package io_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    localparam logic [DATA_W-1:0] HEADER_MASK = {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        SCAN,
        SAT,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/rle_out_reg.sv
// Single-entry valid/ready holding register for encoded words.
//   clk, rst    clock, synchronous active-low reset
//   load        write load_data this cycle (caller guarantees !stall)
//   load_data   word to hold
//   dout_ready  downstream accept
//   dout        held word
//   dout_valid  dout holds an unaccepted word
//   stall       entry full and not being drained this cycle
import io_pkg::*;

module rle_out_reg (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              stall
);

    assign stall = dout_valid && !dout_ready;

    // A load on the acceptance cycle replaces the word, so emits can run
    // back-to-back while downstream keeps dout_ready high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (load) begin
            dout       <= load_data;
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rle_compressor.sv
// Run-length encoder: scans raw bitmap words LSB-first, one bit per clock,
// and emits a header word {0, first_bit} followed by alternating run lengths.
//   clk, rst              clock, synchronous active-low reset
//   start                 begin a new frame (only honoured in IDLE)
//   din/din_valid/din_last/din_ready   raw word input, last word flag
//   dout/dout_valid/dout_ready         encoded word output
//   done                  one-cycle pulse after the final run is accepted
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | din_ready high, capturing next raw word
// HEADER | emit {0, first_bit}, seed run counter
// SCAN   | consume one bit per cycle, emit run on bit change / saturation
// SAT    | emit zero-length filler run after a MAX_RUN word
// FLUSH  | emit final run, wait for it to be accepted
// DONE   | done pulse
import io_pkg::*;

module rle_compressor (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              din_last,
    output logic              din_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              done
);

    localparam int               BL_W      = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] MAX_RUN   = '1;
    localparam logic [CNT_W-1:0] RUN_ONE   = CNT_W'(1);
    localparam logic [BL_W-1:0]  WORD_BITS = BL_W'(DATA_W);
    localparam logic [BL_W-1:0]  BL_ONE    = BL_W'(1);

    state_t            state;
    logic [DATA_W-1:0] sr;
    logic [BL_W-1:0]   bits_left;
    logic [CNT_W-1:0]  run;
    logic              cur_bit;
    logic              last_r;
    logic              first_r;
    logic              flush_sent;

    logic              emit;
    logic [DATA_W-1:0] emit_word;
    logic              stall;
    logic              bit_diff;
    logic              run_full;
    logic              scan_go;

    assign din_ready = (state == LOAD);
    assign bit_diff  = (sr[0] != cur_bit);
    assign run_full  = (run == MAX_RUN);
    // A bit that needs no output word is consumed even if the output is full.
    assign scan_go   = (state == SCAN) && (!(bit_diff || run_full) || !stall);

    always_comb begin
        emit      = 1'b0;
        emit_word = '0;
        case (state)
            HEADER: begin
                emit      = !stall;
                emit_word = sr[0] ? HEADER_MASK : '0;
            end
            SCAN: begin
                emit      = scan_go && (bit_diff || run_full);
                emit_word = DATA_W'(run);
            end
            SAT: begin
                emit = !stall;
            end
            FLUSH: begin
                emit      = !flush_sent && !stall;
                emit_word = DATA_W'(run);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sr         <= '0;
            bits_left  <= '0;
            run        <= '0;
            cur_bit    <= 1'b0;
            last_r     <= 1'b0;
            first_r    <= 1'b0;
            flush_sent <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        first_r <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (din_valid) begin
                        sr        <= din;
                        bits_left <= WORD_BITS;
                        last_r    <= din_last;
                        first_r   <= 1'b0;
                        state     <= first_r ? HEADER : SCAN;
                    end
                end
                HEADER: begin
                    if (!stall) begin
                        cur_bit <= sr[0];
                        run     <= '0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_go) begin
                        sr        <= sr >> 1;
                        bits_left <= bits_left - BL_ONE;
                        if (bit_diff) begin
                            cur_bit <= ~cur_bit;
                            run     <= RUN_ONE;
                        end else if (run_full) begin
                            run <= RUN_ONE;
                        end else begin
                            run <= run + RUN_ONE;
                        end
                        // Saturation: MAX_RUN already loaded, the zero filler
                        // follows from SAT before the word/frame boundary.
                        if (!bit_diff && run_full)
                            state <= SAT;
                        else if (bits_left == BL_ONE)
                            state <= last_r ? FLUSH : LOAD;
                    end
                end
                SAT: begin
                    if (!stall) begin
                        if (bits_left == '0)
                            state <= last_r ? FLUSH : LOAD;
                        else
                            state <= SCAN;
                    end
                end
                FLUSH: begin
                    if (!flush_sent) begin
                        if (!stall)
                            flush_sent <= 1'b1;
                    end else if (dout_ready) begin
                        flush_sent <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    rle_out_reg u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (emit),
        .load_data  (emit_word),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .stall      (stall)
    );

endmodule

// File: tb/tb_rle_compressor.sv
module tb_rle_compressor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_last = 1'b0;
    logic        din_ready;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [15:0] frame_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] got[$];
    int          done_cnt;
    int          hs_cyc;
    int          hdr_cyc;
    int          done_cyc;

    always #5 clk = ~clk;

    rle_compressor dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din        (din),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .done       (done)
    );

    // Accepted words and done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst && dout_valid && dout_ready) got.push_back(dout);
        if (rst && done) done_cnt++;
    end

    // Reference: walk all bits of the frame, split into runs, and break any
    // run longer than 65535 into 65535, 0, remainder.
    function automatic void push_run(input int len);
        int l;
        l = len;
        while (l > 65535) begin
            exp_q.push_back(16'hFFFF);
            exp_q.push_back(16'h0000);
            l -= 65535;
        end
        exp_q.push_back(16'(l));
    endfunction

    function automatic void build_model();
        int   len;
        logic cur;
        logic b;
        exp_q.delete();
        cur = frame_q[0][0];
        exp_q.push_back({15'b0, cur});
        len = 0;
        foreach (frame_q[w]) begin
            for (int i = 0; i < 16; i++) begin
                b = frame_q[w][i];
                if (b == cur) len++;
                else begin
                    push_run(len);
                    cur = b;
                    len = 1;
                end
            end
        end
        push_run(len);
    endfunction

    function automatic int first_diff();
        int n;
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got[i] !== exp_q[i]) return i;
        if (got.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic int run_sum();
        int s;
        s = 0;
        for (int i = 1; i < got.size(); i++) s += int'(got[i]);
        return s;
    endfunction

    function automatic logic [15:0] rand_word();
        case ($urandom_range(3))
            0: return 16'h0000;
            1: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Drives one frame from frame_q. abort_at >= 0 asserts reset at that
    // cycle and returns early; spurious_at pulses start mid-frame.
    task automatic run_frame(input int pct, input int spurious_at,
                             input int abort_at, output bit timed_out);
        int idx;
        int cyc;
        int n;
        int limit;
        bit seen_done;
        idx = 0; cyc = 0; seen_done = 0; timed_out = 0;
        n = frame_q.size();
        limit = ((pct >= 100) ? 20 : 200) * n + 200;
        got.delete();
        done_cnt = 0; hs_cyc = -1; hdr_cyc = -1; done_cyc = -1;
        @(posedge clk); #1;
        start = 1'b1; din_valid = 1'b0; dout_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen_done) begin
            if (cyc >= limit) begin
                timed_out = 1;
                break;
            end
            if (cyc == abort_at) begin
                rst = 1'b0;
                start = 1'b0;
                din_valid = 1'b0;
                return;
            end
            start      = (cyc == spurious_at);
            din_valid  = (idx < n);
            din        = (idx < n) ? frame_q[idx] : 16'h0000;
            din_last   = (idx == n - 1);
            dout_ready = ($urandom_range(99) < pct);
            @(negedge clk);
            if (din_valid && din_ready) begin
                if (idx == 0) hs_cyc = cyc;
                idx++;
            end
            if (dout_valid && hdr_cyc < 0) hdr_cyc = cyc;
            if (done) begin
                seen_done = 1;
                done_cyc = cyc;
            end
            cyc++;
            @(posedge clk); #1;
        end
        start = 1'b0; din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (timed_out) begin
            checks++; errors++;
            $display("FAIL frame_timeout: no done within %0d cycles (got %0d words)", limit, got.size());
            rst = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready: got %b required 0", din_ready); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b required 0", dout_valid); end
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h required 0000", dout); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_single_words();
        logic [15:0] pats[3];
        bit to;
        int bad;
        pats = '{16'h0000, 16'hFFFF, 16'h00FF};
        foreach (pats[p]) begin
            frame_q = {pats[p]};
            build_model();
            run_frame(100, -1, -1, to);
            bad = first_diff();
            checks++;
            if (bad != -1) begin
                errors++;
                $display("FAIL single_%h_stream: word %0d got %h required %h (%0d words, required %0d)",
                         pats[p], bad, (bad < got.size()) ? got[bad] : 16'hxxxx,
                         (bad < exp_q.size()) ? exp_q[bad] : 16'hxxxx, got.size(), exp_q.size());
            end
            checks++;
            if (done_cnt !== 1) begin errors++; $display("FAIL single_%h_done: got %0d pulses required 1", pats[p], done_cnt); end
            checks++;
            if (hdr_cyc - hs_cyc !== 2) begin
                errors++;
                $display("FAIL single_%h_hdr_latency: got %0d cycles required 2", pats[p], hdr_cyc - hs_cyc);
            end
        end
    endtask

    task automatic test_seam();
        bit to;
        int bad;
        frame_q = {16'h5555, 16'hAAAA};
        build_model();
        run_frame(100, -1, -1, to);
        bad = first_diff();
        checks++;
        if (bad != -1) begin
            errors++;
            $display("FAIL seam_stream: word %0d got %h required %h (%0d words, required %0d)",
                     bad, (bad < got.size()) ? got[bad] : 16'hxxxx,
                     (bad < exp_q.size()) ? exp_q[bad] : 16'hxxxx, got.size(), exp_q.size());
        end
        checks++;
        if (run_sum() !== 32) begin errors++; $display("FAIL seam_sum: got %0d required 32", run_sum()); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL seam_done: got %0d pulses required 1", done_cnt); end
    endtask

    // With dout_ready always high every emit must load while the previous
    // word drains, so a frame costs LOAD+HEADER, 17 cycles per extra word,
    // 16 scan cycles, and the flush/acceptance cycles.
    task automatic test_back_to_back();
        bit to;
        int bad;
        frame_q = {16'h5555, 16'h5555, 16'h3333};
        build_model();
        run_frame(100, -1, -1, to);
        bad = first_diff();
        checks++;
        if (bad != -1) begin
            errors++;
            $display("FAIL b2b_stream: word %0d got %h required %h (%0d words, required %0d)",
                     bad, (bad < got.size()) ? got[bad] : 16'hxxxx,
                     (bad < exp_q.size()) ? exp_q[bad] : 16'hxxxx, got.size(), exp_q.size());
        end
        checks++;
        if (done_cyc < 0 || done_cyc > 17 * 3 + 3) begin
            errors++;
            $display("FAIL b2b_throughput: done at cycle %0d required <= %0d", done_cyc, 17 * 3 + 3);
        end
    endtask

    task automatic test_reset_mid_scan();
        bit to;
        int bad;
        frame_q = {rand_word(), 16'h0F0F};
        build_model();
        run_frame(30, -1, 12, to);
        @(posedge clk);
        @(negedge clk);
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL midrst_din_ready: got %b required 0", din_ready); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL midrst_dout_valid: got %b required 0", dout_valid); end
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL midrst_dout: got %h required 0000", dout); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b required 0", done); end
        @(posedge clk); #1 rst = 1'b1;
        frame_q = {rand_word(), rand_word(), rand_word()};
        build_model();
        run_frame(30, -1, -1, to);
        bad = first_diff();
        checks++;
        if (bad != -1) begin
            errors++;
            $display("FAIL midrst_restart_stream: word %0d got %h required %h (%0d words, required %0d)",
                     bad, (bad < got.size()) ? got[bad] : 16'hxxxx,
                     (bad < exp_q.size()) ? exp_q[bad] : 16'hxxxx, got.size(), exp_q.size());
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL midrst_restart_done: got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_random();
        bit to;
        int bad;
        int n;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(4, 1);
            frame_q.delete();
            for (int k = 0; k < n; k++) frame_q.push_back(rand_word());
            build_model();
            run_frame(30, (f % 2 == 0) ? 7 : -1, -1, to);
            bad = first_diff();
            checks++;
            if (bad != -1) begin
                errors++;
                $display("FAIL random%0d_stream: word %0d got %h required %h (%0d words, required %0d)",
                         f, bad, (bad < got.size()) ? got[bad] : 16'hxxxx,
                         (bad < exp_q.size()) ? exp_q[bad] : 16'hxxxx, got.size(), exp_q.size());
            end
            checks++;
            if (run_sum() !== 16 * n) begin errors++; $display("FAIL random%0d_sum: got %0d required %0d", f, run_sum(), 16 * n); end
            checks++;
            if (done_cnt !== 1) begin errors++; $display("FAIL random%0d_done: got %0d pulses required 1", f, done_cnt); end
        end
    endtask

    task automatic test_saturation();
        bit to;
        int bad;
        frame_q.delete();
        for (int k = 0; k < 4097; k++) frame_q.push_back(16'h0000);
        build_model();
        run_frame(100, -1, -1, to);
        bad = first_diff();
        checks++;
        if (bad != -1) begin
            errors++;
            $display("FAIL sat_stream: word %0d got %h required %h (%0d words, required %0d)",
                     bad, (bad < got.size()) ? got[bad] : 16'hxxxx,
                     (bad < exp_q.size()) ? exp_q[bad] : 16'hxxxx, got.size(), exp_q.size());
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL sat_done: got %0d pulses required 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_words();
        test_seam();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
